// File: rtl/counter_share_ctrl.sv
// counter_share_ctrl: round-robin sharing of one external up-counter, clearing it and enabling it for a requested length
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   req        : per-requester request level, held until done or abort
//   req_len    : packed target lengths, slice i = req_len[i*CNT_W +: CNT_W]
//   cnt_value  : current value of the shared counter
//   cnt_reset  : drives the counter's synchronous reset
//   cnt_enable : drives the counter's enable
//   grant      : one-hot owner of the counter, zero when idle
//   busy       : high while a job owns the counter
//   done       : one-cycle completion pulse
//   done_id    : index of the completed requester, valid with done
module counter_share_ctrl #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W = 4,
   parameter int ID_W = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CNT_W-1:0] req_len,
   input  logic [CNT_W-1:0]         cnt_value,
   output logic                     cnt_reset,
   output logic                     cnt_enable,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     busy,
   output logic                     done,
   output logic [ID_W-1:0]          done_id
);
   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
   state_t state;
   logic [ID_W-1:0] id, ptr, pick, nxt;
   logic [CNT_W-1:0] target;
   int idx;
   // Scan from the farthest candidate back to the pointer so the last hit is the first asserted requester at or after ptr.
   always_comb begin
      pick = '0;
      idx = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (req[idx]) pick = ID_W'(idx);
      end
   end
   assign nxt = ID_W'((int'(id) + 1) % NUM_REQ);
   // Enable depends only on state and the counter value, so the counter gets exactly target pulses.
   assign cnt_enable = (state == RUN) && (cnt_value != target);
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         id <= '0;
         ptr <= '0;
         target <= '0;
         grant <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         done_id <= '0;
         cnt_reset <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               done_id <= '0;
               if (|req) begin
                  id <= pick;
                  target <= req_len[pick*CNT_W +: CNT_W];
                  grant <= NUM_REQ'(1) << pick;
                  busy <= 1'b1;
                  cnt_reset <= 1'b1;
                  state <= CLEAR;
               end
            end
            CLEAR, RUN: begin
               cnt_reset <= 1'b0;
               if (!req[id]) begin
                  grant <= '0;
                  busy <= 1'b0;
                  ptr <= nxt;
                  state <= IDLE;
               end else if (state == CLEAR) begin
                  state <= RUN;
               end else if (cnt_value == target) begin
                  done <= 1'b1;
                  done_id <= id;
                  state <= DONE;
               end
            end
            default: begin
               done <= 1'b0;
               done_id <= '0;
               grant <= '0;
               busy <= 1'b0;
               ptr <= nxt;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
